// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single byte-serial memory controller between the
// instruction-fetch requester (IF) and the load/store buffer requester (LS).
// One task is in flight at a time: IDLE -> ISSUE -> WAIT -> DONE.
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking; when it is
// undefined, LS has fixed priority over IF and no pointer register exists.
module mem_arbiter #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        io_buffer_full,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_valid,
  input  logic        ls_write,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_type,
  output logic        ls_done,
  output logic [31:0] ls_data,
  output logic        mc_new_task,
  output logic        mc_is_write,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_data_in,
  output logic [2:0]  mc_work_type,
  input  logic [31:0] mc_data_out,
  input  logic        mc_ready,
  input  logic        mc_is_working
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_data_q, ls_data_d;

  logic ls_io_blocked;
  logic ls_elig;
  logic if_elig;
  logic grant;
  logic grant_ls;
  logic read_abort;

  // Eligibility: I/O stores wait for UART space; a flush only lets stores in.
  always_comb begin
    ls_io_blocked = ls_write && (ls_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
    ls_elig       = ls_valid && !ls_io_blocked && (!rob_clear || ls_write);
    if_elig       = if_valid && !rob_clear;
    grant         = ls_elig || if_elig;
  end

`ifdef MEM_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  // On a tie, favour whichever requester was not granted last.
  always_comb begin
    grant_ls  = ls_elig && (!if_elig || (rr_last_q == OWNER_IF));
    rr_last_d = rr_last_q;
    if (rdy_in && (state_q == IDLE) && grant) begin
      rr_last_d = grant_ls;
    end
  end

  // Round-robin pointer: remembers the last granted requester.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_last_q <= OWNER_IF;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  // Fixed priority: LS wins whenever it is eligible.
  always_comb begin
    grant_ls = ls_elig;
  end
`endif

  // A flush kills an in-flight read; stores always run to completion.
  assign read_abort = rob_clear && !write_q;

  // Next-state and latched task fields; everything holds while rdy_in is low.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    type_d    = type_q;
    if_data_d = if_data_q;
    ls_data_d = ls_data_q;
    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_d = ISSUE;
            owner_d = grant_ls;
            if (grant_ls) begin
              write_d = ls_write;
              addr_d  = ls_addr;
              wdata_d = ls_wdata;
              type_d  = ls_type;
            end else begin
              write_d = 1'b0;
              addr_d  = if_addr;
              wdata_d = 32'h0;
              type_d  = 3'b010;
            end
          end
        end
        ISSUE: begin
          // The pulse is held back while the controller is still busy.
          if (read_abort) begin
            state_d = IDLE;
          end else if (!mc_is_working) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (read_abort) begin
            state_d = IDLE;
          end else if (!mc_is_working) begin
            if (write_q) begin
              state_d = DONE;
            end else if (mc_ready) begin
              state_d = DONE;
              if (owner_q == OWNER_LS) begin
                ls_data_d = mc_data_out;
              end else begin
                if_data_d = mc_data_out;
              end
            end else begin
              // Controller dropped the read: retry through arbitration.
              state_d = IDLE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and task registers; reset drops any task in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_IF;
      write_q   <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      type_q    <= 3'b000;
      if_data_q <= 32'h0;
      ls_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      type_q    <= type_d;
      if_data_q <= if_data_d;
      ls_data_q <= ls_data_d;
    end
  end

  // Outputs: task pulse only in ISSUE with an idle controller; done pulses
  // are masked the same cycle a flush hits a read.
  always_comb begin
    mc_new_task  = rdy_in && (state_q == ISSUE) && !mc_is_working && !read_abort;
    mc_is_write  = write_q;
    mc_addr      = addr_q;
    mc_data_in   = wdata_q;
    mc_work_type = type_q;
    if_done      = (state_q == DONE) && (owner_q == OWNER_IF) && !read_abort;
    ls_done      = (state_q == DONE) && (owner_q == OWNER_LS) && !read_abort;
    if_data      = if_data_q;
    ls_data      = ls_data_q;
  end

endmodule
